// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller and shared memory-port arbiter.
//
// A CPU write to REG_ADDR latches the source page and, after START_DELAY
// clocks, copies LEN bytes from {src, 8'h00} into OAM at 16'hFE00. Each byte
// takes CYCLES_PER_BYTE clocks: phase 0 reads the source, phase 1 writes OAM,
// and the remaining phases leave the port free for CPU accesses at or above
// 16'hFF00. Lower CPU accesses are blocked for the whole copy.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   cpu_addr        CPU address
//   cpu_data_in     CPU write data
//   cpu_rd, cpu_wr  one-cycle CPU read / write strobes
//   cpu_data_out    CPU read data, valid the cycle after cpu_rd
//   cpu_wait        CPU must hold its request this cycle
//   mem_addr        shared memory address
//   mem_wdata       shared memory write data
//   mem_rd, mem_wr  memory strobes; mem_rdata is valid the cycle after mem_rd
//   mem_rdata       memory read data
//   dma_active      high from the trigger write until the last byte is written
module oam_dma_ctrl #(
   parameter logic [15:0] REG_ADDR        = 16'hFF46,
   parameter int unsigned LEN             = 160,
   parameter int unsigned CYCLES_PER_BYTE = 4,
   parameter int unsigned START_DELAY     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_wait,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active
);

   localparam int unsigned PW = $clog2(CYCLES_PER_BYTE);
   localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

   localparam logic [PW-1:0] LAST_PHASE = PW'(CYCLES_PER_BYTE - 1);
   localparam logic [DW-1:0] LAST_DELAY = DW'(START_DELAY - 1);
   localparam logic [7:0]    LAST_IDX   = 8'(LEN - 1);
   localparam logic [15:0]   OAM_BASE   = 16'hFE00;
   localparam logic [15:0]   HIGH_BASE  = 16'hFF00;

   typedef enum logic [1:0] {StIdle, StDelay, StXfer} state_e;

   // Source of cpu_data_out in the cycle after a read.
   typedef enum logic [1:0] {RdNone, RdMem, RdReg} rd_src_e;

   state_e        state_q, state_d;
   rd_src_e       rd_src_q, rd_src_d;
   logic [7:0]    src_q, src_d;
   logic [7:0]    idx_q, idx_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [DW-1:0] delay_q, delay_d;

   logic is_reg;
   logic is_high;

   assign is_reg  = (cpu_addr == REG_ADDR);
   assign is_high = (cpu_addr >= HIGH_BASE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         rd_src_q <= RdNone;
         src_q    <= 8'h00;
         idx_q    <= 8'h00;
         phase_q  <= '0;
         delay_q  <= '0;
      end else begin
         state_q  <= state_d;
         rd_src_q <= rd_src_d;
         src_q    <= src_d;
         idx_q    <= idx_d;
         phase_q  <= phase_d;
         delay_q  <= delay_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rd_src_d  = RdNone;
      src_d     = src_q;
      idx_d     = idx_q;
      phase_d   = phase_q;
      delay_d   = delay_q;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_data_in;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      cpu_wait  = 1'b0;

      unique case (state_q)
         StIdle, StDelay: begin
            // CPU owns the port; the register itself never reaches memory.
            if (!is_reg) begin
               mem_rd = cpu_rd;
               mem_wr = cpu_wr;
               if (cpu_rd) begin
                  rd_src_d = RdMem;
               end
            end
            if (state_q == StDelay) begin
               if (delay_q == LAST_DELAY) begin
                  state_d = StXfer;
                  idx_d   = 8'h00;
                  phase_d = '0;
               end else begin
                  delay_d = delay_q + DW'(1);
               end
            end
         end

         StXfer: begin
            if (phase_q == PW'(0)) begin
               mem_rd   = 1'b1;
               mem_addr = {src_q, idx_q};
            end else if (phase_q == PW'(1)) begin
               // Source byte read in phase 0 is on mem_rdata now; write it straight through.
               mem_wr    = 1'b1;
               mem_addr  = OAM_BASE + {8'h00, idx_q};
               mem_wdata = mem_rdata;
            end else if (is_high && !is_reg) begin
               mem_rd = cpu_rd;
               mem_wr = cpu_wr;
               if (cpu_rd) begin
                  rd_src_d = RdMem;
               end
            end
            // High-page requests stall while the DMA holds the port; low ones are
            // simply blocked (read returns 8'hFF, write is dropped).
            if (is_high && !is_reg && (cpu_rd || cpu_wr) && (phase_q < PW'(2))) begin
               cpu_wait = 1'b1;
            end
            if (phase_q == LAST_PHASE) begin
               phase_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end

         default: state_d = StIdle;
      endcase

      if (cpu_rd && is_reg) begin
         rd_src_d = RdReg;
      end

      // Trigger/restart wins over everything, including end of transfer.
      if (cpu_wr && is_reg) begin
         src_d   = cpu_data_in;
         idx_d   = 8'h00;
         phase_d = '0;
         delay_d = '0;
         state_d = StDelay;
      end

      // Outputs collapse to their idle values while reset is held.
      if (reset) begin
         mem_addr  = 16'h0000;
         mem_wdata = 8'h00;
         mem_rd    = 1'b0;
         mem_wr    = 1'b0;
         cpu_wait  = 1'b0;
      end
   end

   always_comb begin
      unique case (rd_src_q)
         RdMem:   cpu_data_out = mem_rdata;
         RdReg:   cpu_data_out = src_q;
         default: cpu_data_out = 8'hFF;
      endcase
   end

   assign dma_active = (state_q != StIdle);

endmodule
